wb_cmd_initiator: RTL and testbench

//  Wishbone classic initiator: turns single commands (valid/ready) into one
//  bus read or write on the user-area Wishbone slave, then returns the result.

---
 rtl/wb_cmd_initiator.sv | 157 +++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: accepts one command over valid/ready, runs a
// single read or write on the bus and hands the result back over valid/ready.
// A per-access ack timeout aborts the cycle if the slave never answers.
module wb_cmd_initiator #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // command channel
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW-1:0]     cmd_dat_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  // response channel
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_timeout_o,
  // Wishbone initiator side
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen during the last permitted bus cycle.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            cyc_q,       cyc_d;
  logic            we_q,        we_d;
  logic [SW-1:0]   sel_q,       sel_d;
  logic [AW-1:0]   adr_q,       adr_d;
  logic [DW-1:0]   wdat_q,      wdat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q,   rsp_dat_d;
  logic            rsp_to_q,    rsp_to_d;

  // Next-state and registered-output logic for the IDLE/BUS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_to_d    = rsp_to_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          wdat_d  = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack arriving on the expiry cycle still completes normally.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          state_d     = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    // Registered so it rises in the cycle right after the response handshake.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_timeout_o = rsp_to_q;
  // Classic single access: strobe is asserted for the whole cycle.
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_sel_o      = sel_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = wdat_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator with TIMEOUT=8.
module tb_wb_cmd_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [31:0]   cmd_adr, cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_to;
  logic [31:0]   rsp_dat;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dato;
  logic          ack;
  logic [31:0]   dati;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_timeout_o(rsp_to),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
    .wb_adr_o(adr), .wb_dat_o(dato), .wb_ack_i(ack), .wb_dat_i(dati)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for cmd_ready_o; ok reports whether it came.
  task automatic wait_ready(output bit ok);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 30) begin
      tick();
      guard++;
    end
    ok = (cmd_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_to, rsp_dat} !== 35'd0)
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b to=%b rsp_dat=%h required all 0",
               cmd_ready, rsp_valid, rsp_to, rsp_dat);
    else n_pass++;
    n_checks++;
    if ({cyc, stb, we, sel, adr, dato} !== 71'd0)
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required all 0",
               cyc, stb, we, sel, adr, dato);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({cmd_ready, cyc} !== 2'b10)
      $display("FAIL reset_release: ready=%b cyc=%b required 1/0", cmd_ready, cyc);
    else n_pass++;
  endtask

  task automatic test_write();
    bit ok;
    wait_ready(ok);
    n_checks++;
    if (!ok) $display("FAIL write_ready: cmd_ready_o=%b required 1", cmd_ready);
    else n_pass++;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
    cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({cyc, stb, we, sel, adr, dato, cmd_ready, rsp_valid} !==
          {1'b1, 1'b1, 1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0})
        $display("FAIL write_bus c%0d: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rdy=%b rv=%b required 1 1 1 f 30000004 deadbeef 0 0",
                 c, cyc, stb, we, sel, adr, dato, cmd_ready, rsp_valid);
      else n_pass++;
      if (c == 2) begin
        ack = 1'b1;
        dati = 32'h5555_AAAA;
      end
      tick();
    end
    ack = 1'b0;
    n_checks++;
    if ({cyc, stb, rsp_valid, rsp_to, rsp_dat, we, adr} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000_0004})
      $display("FAIL write_rsp: cyc=%b stb=%b rv=%b to=%b rdat=%h we=%b adr=%h required 0 0 1 0 0 1 30000004",
               cyc, stb, rsp_valid, rsp_to, rsp_dat, we, adr);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL write_done: rv=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_read_fast();
    bit ok;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000;
    cmd_dat = 32'h0; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({cyc, we, adr, rsp_valid} !== {1'b1, 1'b0, 32'h3000_0000, 1'b0})
      $display("FAIL read_bus: cyc=%b we=%b adr=%h rv=%b required 1 0 30000000 0",
               cyc, we, adr, rsp_valid);
    else n_pass++;
    ack = 1'b1; dati = 32'h1234_5678;
    tick();
    ack = 1'b0; dati = 32'h0;
    n_checks++;
    if ({rsp_valid, rsp_to, rsp_dat, cyc} !== {1'b1, 1'b0, 32'h1234_5678, 1'b0})
      $display("FAIL read_rsp: rv=%b to=%b rdat=%h cyc=%b required 1 0 12345678 0",
               rsp_valid, rsp_to, rsp_dat, cyc);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc_cnt;
    wait_ready(ok);
    dati = 32'hFEED_F00D;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    cyc_cnt = 0;
    while (cyc === 1'b1 && cyc_cnt < 40) begin
      cyc_cnt++;
      tick();
    end
    n_checks++;
    if (cyc_cnt != TO)
      $display("FAIL timeout_len: cyc high %0d cycles required %0d", cyc_cnt, TO);
    else n_pass++;
    n_checks++;
    if ({rsp_valid, rsp_to, rsp_dat, stb} !== {1'b1, 1'b1, 32'h0, 1'b0})
      $display("FAIL timeout_rsp: rv=%b to=%b rdat=%h stb=%b required 1 1 0 0",
               rsp_valid, rsp_to, rsp_dat, stb);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // Ack arrives in the eighth (final) bus cycle: normal completion wins.
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0014;
    tick();
    cmd_valid = 1'b0;
    repeat (TO - 1) tick();
    n_checks++;
    if (cyc !== 1'b1)
      $display("FAIL late_ack_cyc: cyc=%b in bus cycle 8 required 1", cyc);
    else n_pass++;
    ack = 1'b1; dati = 32'hA5A5_0008;
    tick();
    ack = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_to, rsp_dat, cyc} !== {1'b1, 1'b0, 32'hA5A5_0008, 1'b0})
      $display("FAIL late_ack_rsp: rv=%b to=%b rdat=%h cyc=%b required 1 0 a5a50008 0",
               rsp_valid, rsp_to, rsp_dat, cyc);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008;
    tick();
    cmd_valid = 1'b0;
    ack = 1'b1; dati = 32'hCAFE_0004;
    tick();
    for (int k = 0; k < 5; k++) begin
      ack = 1'b1; dati = 32'h0BAD_0000 + k; cmd_valid = 1'b1;
      n_checks++;
      if ({rsp_valid, rsp_to, rsp_dat, cmd_ready, cyc} !== {1'b1, 1'b0, 32'hCAFE_0004, 1'b0, 1'b0})
        $display("FAIL hold_rsp k%0d: rv=%b to=%b rdat=%h ready=%b cyc=%b required 1 0 cafe0004 0 0",
                 k, rsp_valid, rsp_to, rsp_dat, cmd_ready, cyc);
      else n_pass++;
      tick();
    end
    ack = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready, cyc} !== 3'b010)
      $display("FAIL hold_release: rv=%b ready=%b cyc=%b required 0 1 0",
               rsp_valid, cmd_ready, cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    bit ok;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_000C;
    cmd_dat = 32'h1111_2222; cmd_sel = 4'h3;
    tick();
    cmd_valid = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({cyc, stb, rsp_valid, cmd_ready, adr} !== 36'd0)
      $display("FAIL async_reset: cyc=%b stb=%b rv=%b ready=%b adr=%h required all 0",
               cyc, stb, rsp_valid, cmd_ready, adr);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({cmd_ready, cyc, rsp_valid} !== 3'b100)
      $display("FAIL reset_recover: ready=%b cyc=%b rv=%b required 1 0 0",
               cmd_ready, cyc, rsp_valid);
    else n_pass++;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020;
    cmd_dat = 32'h7777_8888; cmd_sel = 4'hC;
    tick();
    cmd_valid = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_to, rsp_dat, adr, dato, sel} !==
        {1'b1, 1'b0, 32'h0, 32'h3000_0020, 32'h7777_8888, 4'hC})
      $display("FAIL post_reset_cmd: rv=%b to=%b rdat=%h adr=%h dat=%h sel=%h required 1 0 0 30000020 77778888 c",
               rsp_valid, rsp_to, rsp_dat, adr, dato, sel);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] mem [4];
    bit          ok;
    logic        r_we;
    int          idx, w, rw;
    logic [31:0] r_adr, r_dat, exp;
    logic [3:0]  r_sel;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 * (i + 1);
    for (int t = 0; t < 24; t++) begin
      r_we  = 1'($urandom_range(0, 1));
      idx   = $urandom_range(0, 3);
      r_adr = 32'h3000_0000 | (32'(idx) << 2);
      r_dat = $urandom;
      r_sel = 4'($urandom_range(1, 15));
      w     = $urandom_range(0, 4);
      rw    = $urandom_range(0, 2);
      wait_ready(ok);
      n_checks++;
      if (!ok || cyc !== 1'b0)
        $display("FAIL rnd_idle t%0d: ready=%b cyc=%b required 1 0", t, cmd_ready, cyc);
      else n_pass++;
      cmd_valid = 1'b1; cmd_we = r_we; cmd_adr = r_adr; cmd_dat = r_dat; cmd_sel = r_sel;
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if ({cyc, stb, we, sel, adr, dato} !== {1'b1, 1'b1, r_we, r_sel, r_adr, r_dat})
        $display("FAIL rnd_bus t%0d: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required 1 1 %b %h %h %h",
                 t, cyc, stb, we, sel, adr, dato, r_we, r_sel, r_adr, r_dat);
      else n_pass++;
      repeat (w) tick();
      ack = 1'b1;
      dati = r_we ? 32'hFFFF_FFFF : mem[idx];
      exp  = r_we ? 32'h0 : mem[idx];
      if (r_we)
        for (int b = 0; b < 4; b++)
          if (r_sel[b]) mem[idx][8*b +: 8] = r_dat[8*b +: 8];
      tick();
      ack = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_to, rsp_dat, cyc} !== {1'b1, 1'b0, exp, 1'b0})
        $display("FAIL rnd_rsp t%0d: rv=%b to=%b rdat=%h cyc=%b required 1 0 %h 0",
                 t, rsp_valid, rsp_to, rsp_dat, cyc, exp);
      else n_pass++;
      repeat (rw) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dati = '0;
    test_reset();
    test_write();
    test_read_fast();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
